// File: rtl/cpu_program_loader.sv
// cpu_program_loader: bit-serial program loader for the 3-bit CPU.
// Assembles DATA_W-bit words, MSB first, from a serial stream.
// Writes them to CPU RAM addresses 0..PROG_LEN-1, then raises PC_Enable.
// Optional feature macro: CPU_LOADER_CHECKSUM_EN.
//   When defined, an XOR checksum word follows the program and is verified
//   before the CPU is released.
module cpu_program_loader #(
  parameter int DATA_W   = 9,
  parameter int ADDR_W   = 3,
  parameter int PROG_LEN = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              ser_bit,
  input  logic              ser_valid,
  output logic              ser_ready,
  output logic [DATA_W-1:0] RAM_Write_Data,
  output logic [ADDR_W-1:0] RAM_Write_Address,
  output logic              RAM_Write_Enable,
  output logic              PC_Enable,
  output logic              busy,
  output logic              error
);

  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_W - 1);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(PROG_LEN - 1);

`ifdef CPU_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_SHIFT, S_WRITE, S_RUN, S_CHECK, S_ERROR
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_SHIFT, S_WRITE, S_RUN
  } state_t;
`endif

  state_t              r_state;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic [ADDR_W-1:0]   r_word_cnt;
  logic [DATA_W-2:0]   r_shreg;
  logic                r_ser_ready;
  logic [DATA_W-1:0]   r_wr_data;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic                r_wr_en;
  logic                r_pc_en;
  logic                r_busy;
`ifdef CPU_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0]   r_csum;
  logic                r_error;
`endif

  logic                w_xfer;
  logic [DATA_W-1:0]   w_word;

  assign w_xfer = ser_valid & r_ser_ready;
  // Word as it will look once the current bit is shifted in
  assign w_word = {r_shreg, ser_bit};

  assign ser_ready         = r_ser_ready;
  assign RAM_Write_Data    = r_wr_data;
  assign RAM_Write_Address = r_wr_addr;
  assign RAM_Write_Enable  = r_wr_en;
  assign PC_Enable         = r_pc_en;
  assign busy              = r_busy;
`ifdef CPU_LOADER_CHECKSUM_EN
  assign error             = r_error;
`else
  assign error             = 1'b0;
`endif

  // Loader FSM; every output is computed alongside the next state so it is registered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= '0;
      r_word_cnt  <= '0;
      r_shreg     <= '0;
      r_ser_ready <= 1'b0;
      r_wr_data   <= '0;
      r_wr_addr   <= '0;
      r_wr_en     <= 1'b0;
      r_pc_en     <= 1'b0;
      r_busy      <= 1'b0;
`ifdef CPU_LOADER_CHECKSUM_EN
      r_csum      <= '0;
      r_error     <= 1'b0;
`endif
    end else if (abort) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= '0;
      r_word_cnt  <= '0;
      r_shreg     <= '0;
      r_ser_ready <= 1'b0;
      r_wr_data   <= '0;
      r_wr_addr   <= '0;
      r_wr_en     <= 1'b0;
      r_pc_en     <= 1'b0;
      r_busy      <= 1'b0;
`ifdef CPU_LOADER_CHECKSUM_EN
      r_csum      <= '0;
      r_error     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state     <= S_SHIFT;
            r_bit_cnt   <= '0;
            r_word_cnt  <= '0;
            r_shreg     <= '0;
            r_ser_ready <= 1'b1;
            r_busy      <= 1'b1;
`ifdef CPU_LOADER_CHECKSUM_EN
            r_csum      <= '0;
`endif
          end
        end

        S_SHIFT: begin
          if (w_xfer) begin
            r_shreg <= w_word[DATA_W-2:0];
            if (r_bit_cnt == LAST_BIT) begin
              r_bit_cnt   <= '0;
              r_state     <= S_WRITE;
              r_ser_ready <= 1'b0;
              r_wr_en     <= 1'b1;
              r_wr_data   <= w_word;
              r_wr_addr   <= r_word_cnt;
`ifdef CPU_LOADER_CHECKSUM_EN
              r_csum      <= r_csum ^ w_word;
`endif
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end

        S_WRITE: begin
          r_wr_en <= 1'b0;
          if (r_word_cnt == LAST_WORD) begin
`ifdef CPU_LOADER_CHECKSUM_EN
            r_state     <= S_CHECK;
            r_ser_ready <= 1'b1;
`else
            r_state     <= S_RUN;
            r_pc_en     <= 1'b1;
            r_busy      <= 1'b0;
`endif
          end else begin
            r_word_cnt  <= r_word_cnt + 1'b1;
            r_state     <= S_SHIFT;
            r_ser_ready <= 1'b1;
          end
        end

        S_RUN: begin
          r_pc_en <= 1'b1;
        end

`ifdef CPU_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (w_xfer) begin
            r_shreg <= w_word[DATA_W-2:0];
            if (r_bit_cnt == LAST_BIT) begin
              r_bit_cnt   <= '0;
              r_ser_ready <= 1'b0;
              r_busy      <= 1'b0;
              if (w_word == r_csum) begin
                r_state <= S_RUN;
                r_pc_en <= 1'b1;
              end else begin
                r_state <= S_ERROR;
                r_error <= 1'b1;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end

        S_ERROR: begin
          r_error <= 1'b1;
        end
`endif

        default: begin
          r_state     <= S_IDLE;
          r_ser_ready <= 1'b0;
          r_wr_en     <= 1'b0;
          r_pc_en     <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_program_loader.sv
// Testbench for cpu_program_loader: two instances (PROG_LEN=2 and PROG_LEN=7)
// share the serial inputs; each instance has its own start input.
module tb_cpu_program_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start2, start7, abort, ser_bit, ser_valid;

  logic       rdy2, we2, pc2, busy2, err2;
  logic [8:0] data2;
  logic [2:0] addr2;
  logic       rdy7, we7, pc7, busy7, err7;
  logic [8:0] data7;
  logic [2:0] addr7;

  cpu_program_loader #(.DATA_W(9), .ADDR_W(3), .PROG_LEN(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .abort(abort),
    .ser_bit(ser_bit), .ser_valid(ser_valid), .ser_ready(rdy2),
    .RAM_Write_Data(data2), .RAM_Write_Address(addr2), .RAM_Write_Enable(we2),
    .PC_Enable(pc2), .busy(busy2), .error(err2));

  cpu_program_loader #(.DATA_W(9), .ADDR_W(3), .PROG_LEN(7)) dut7 (
    .clk(clk), .reset(reset), .start(start7), .abort(abort),
    .ser_bit(ser_bit), .ser_valid(ser_valid), .ser_ready(rdy7),
    .RAM_Write_Data(data7), .RAM_Write_Address(addr7), .RAM_Write_Enable(we7),
    .PC_Enable(pc7), .busy(busy7), .error(err7));

  int sel = 2;
  logic       o_rdy, o_we, o_pc, o_busy, o_err;
  logic [8:0] o_data;
  logic [2:0] o_addr;

  always_comb begin
    if (sel == 2) begin
      o_rdy = rdy2; o_we = we2; o_pc = pc2; o_busy = busy2; o_err = err2;
      o_data = data2; o_addr = addr2;
    end else begin
      o_rdy = rdy7; o_we = we7; o_pc = pc7; o_busy = busy7; o_err = err7;
      o_data = data7; o_addr = addr7;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [2:0] addr;
    logic [8:0] data;
  } wr_t;
  wr_t seen[$];

  // Strobe monitor for the selected instance
  always @(negedge clk) if (o_we === 1'b1) seen.push_back('{o_addr, o_data});

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_start();
    if (sel == 2) start2 = 1'b1; else start7 = 1'b1;
    ser_valid = 1'b0;
    step();
    start2 = 1'b0;
    start7 = 1'b0;
  endtask

  // Shift one word MSB first, then check the single WRITE cycle
  task automatic send_word(input logic [8:0] w, input int idx, input bit gaps);
    for (int i = 8; i >= 0; i--) begin
      if (gaps) begin
        for (int g = $urandom_range(0, 2); g > 0; g--) begin
          ser_valid = 1'b0;
          ser_bit   = 1'($urandom);
          step();
          n_tests++;
          if (o_we !== 1'b0) begin
            n_fail++;
            $display("FAIL gap_no_strobe: we=%b required 0", o_we);
          end
        end
      end
      ser_valid = 1'b1;
      ser_bit   = w[i];
      step();
    end
    n_tests++;
    if (o_we !== 1'b1 || o_addr !== 3'(idx) || o_data !== w || o_rdy !== 1'b0 || o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL write_cycle: we=%b addr=%0d data=%h rdy=%b busy=%b required we=1 addr=%0d data=%h rdy=0 busy=1",
               o_we, o_addr, o_data, o_rdy, o_busy, idx, w);
    end
    // Bits offered during WRITE must be ignored
    ser_valid = gaps ? 1'b1 : 1'b0;
    ser_bit   = 1'($urandom);
    step();
    ser_valid = 1'b0;
    n_tests++;
    if (o_we !== 1'b0) begin
      n_fail++;
      $display("FAIL strobe_width: we=%b required 0", o_we);
    end
  endtask

  // Full load of n words; flip corrupts the checksum word when that feature is built
  task automatic load(input logic [8:0] w [8], input int n, input bit gaps, input bit flip);
    logic [8:0] x;
    seen.delete();
    do_start();
    n_tests++;
    if (o_rdy !== 1'b1 || o_busy !== 1'b1 || o_pc !== 1'b0) begin
      n_fail++;
      $display("FAIL start_shift: rdy=%b busy=%b pc=%b required 1 1 0", o_rdy, o_busy, o_pc);
    end
    x = '0;
    for (int k = 0; k < n; k++) begin
      send_word(w[k], k, gaps);
      x = x ^ w[k];
    end
`ifdef CPU_LOADER_CHECKSUM_EN
    n_tests++;
    if (o_rdy !== 1'b1 || o_busy !== 1'b1 || o_pc !== 1'b0) begin
      n_fail++;
      $display("FAIL check_state: rdy=%b busy=%b pc=%b required 1 1 0", o_rdy, o_busy, o_pc);
    end
    x = x ^ {8'h00, flip};
    for (int i = 8; i >= 0; i--) begin
      ser_valid = 1'b1;
      ser_bit   = x[i];
      step();
    end
    ser_valid = 1'b0;
    n_tests++;
    if (o_pc !== !flip || o_err !== flip || o_busy !== 1'b0 || o_rdy !== 1'b0 || o_we !== 1'b0) begin
      n_fail++;
      $display("FAIL checksum_result: pc=%b err=%b busy=%b rdy=%b we=%b required pc=%b err=%b busy=0 rdy=0 we=0",
               o_pc, o_err, o_busy, o_rdy, o_we, !flip, flip);
    end
`else
    n_tests++;
    if (o_pc !== 1'b1 || o_busy !== 1'b0 || o_rdy !== 1'b0 || o_err !== 1'b0 || flip) begin
      n_fail++;
      $display("FAIL run_entry: pc=%b busy=%b rdy=%b err=%b required 1 0 0 0", o_pc, o_busy, o_rdy, o_err);
    end
`endif
    n_tests++;
    if (seen.size() != n) begin
      n_fail++;
      $display("FAIL strobe_count: got %0d required %0d", seen.size(), n);
    end else begin
      for (int k = 0; k < n; k++) begin
        n_tests++;
        if (seen[k].addr !== 3'(k) || seen[k].data !== w[k]) begin
          n_fail++;
          $display("FAIL ram_write_%0d: addr=%0d data=%h required addr=%0d data=%h",
                   k, seen[k].addr, seen[k].data, k, w[k]);
        end
      end
    end
  endtask

  task automatic do_abort();
    abort = 1'b1;
    ser_valid = 1'b0;
    step();
    abort = 1'b0;
  endtask

  task automatic test_reset();
    logic [8:0] w;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    n_tests++;
    if ({rdy2, we2, pc2, busy2, err2, data2, addr2, rdy7, we7, pc7, busy7, err7, data7, addr7} !== '0) begin
      n_fail++;
      $display("FAIL reset_initial: outputs not all zero");
    end
    step();
    reset = 1'b1;
    step();
    // Mid-load asynchronous reset on the PROG_LEN=7 instance
    sel = 7;
    seen.delete();
    do_start();
    w = 9'(($urandom_range(1, 511)));
    send_word(w, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      ser_valid = 1'b1; ser_bit = 1'($urandom); step();
    end
    n_tests++;
    if (o_busy !== 1'b1 || o_data !== w) begin
      n_fail++;
      $display("FAIL pre_reset: busy=%b data=%h required busy=1 data=%h", o_busy, o_data, w);
    end
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if ({o_rdy, o_we, o_pc, o_busy, o_err, o_data, o_addr} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: rdy=%b we=%b pc=%b busy=%b data=%h addr=%0d required all 0",
               o_rdy, o_we, o_pc, o_busy, o_data, o_addr);
    end
    step();
    reset = 1'b1;
    ser_valid = 1'b0;
    step();
    n_tests++;
    if (o_rdy !== 1'b0 || o_busy !== 1'b0 || o_pc !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: rdy=%b busy=%b pc=%b required 0 0 0", o_rdy, o_busy, o_pc);
    end
    seen.delete();
    for (int i = 0; i < 12; i++) begin
      ser_valid = 1'b1; ser_bit = 1'($urandom); step();
    end
    ser_valid = 1'b0;
    n_tests++;
    if (seen.size() != 0 || o_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ignores_bits: strobes=%0d rdy=%b required 0 0", seen.size(), o_rdy);
    end
  endtask

  task automatic test_basic_load();
    logic [8:0] w [8];
    sel = 2;
    w = '{9'h10A, 9'h0E4, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0};
    load(w, 2, 1'b0, 1'b0);
    do_abort();
  endtask

  task automatic test_gapped_load();
    logic [8:0] w [8];
    sel = 2;
    w = '{9'h10A, 9'h0E4, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0};
    load(w, 2, 1'b1, 1'b0);
    do_abort();
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 8; k++) w[k] = 9'($urandom);
      load(w, 2, 1'b1, 1'b0);
      do_abort();
    end
  endtask

  task automatic test_abort();
    logic [8:0] w [8];
    sel = 7;
    for (int k = 0; k < 8; k++) w[k] = 9'($urandom);
    seen.delete();
    do_start();
    send_word(w[0], 0, 1'b0);
    send_word(w[1], 1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      ser_valid = 1'b1; ser_bit = 1'($urandom); step();
    end
    do_abort();
    n_tests++;
    if (o_busy !== 1'b0 || o_rdy !== 1'b0 || o_we !== 1'b0 || o_data !== 9'h0 || o_addr !== 3'h0) begin
      n_fail++;
      $display("FAIL abort_idle: busy=%b rdy=%b we=%b data=%h addr=%0d required all 0",
               o_busy, o_rdy, o_we, o_data, o_addr);
    end
    n_tests++;
    if (seen.size() != 2) begin
      n_fail++;
      $display("FAIL abort_strobes: got %0d required 2", seen.size());
    end
    // start with abort resolves to abort
    start7 = 1'b1; abort = 1'b1;
    step();
    start7 = 1'b0; abort = 1'b0;
    n_tests++;
    if (o_busy !== 1'b0 || o_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL start_abort_same: busy=%b rdy=%b required 0 0", o_busy, o_rdy);
    end
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 8; k++) w[k] = 9'($urandom);
      load(w, 7, r[0], 1'b0);
      do_abort();
    end
  endtask

  task automatic test_run();
    logic [8:0] w [8];
    sel = 2;
    for (int k = 0; k < 8; k++) w[k] = 9'($urandom);
    load(w, 2, 1'b0, 1'b0);
    seen.delete();
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ser_valid = 1'b1; ser_bit = 1'($urandom); step();
    end
    ser_valid = 1'b0;
    n_tests++;
    if (o_pc !== 1'b1 || o_busy !== 1'b0 || o_rdy !== 1'b0 || seen.size() != 0) begin
      n_fail++;
      $display("FAIL run_ignores_start: pc=%b busy=%b rdy=%b strobes=%0d required 1 0 0 0",
               o_pc, o_busy, o_rdy, seen.size());
    end
    do_abort();
    n_tests++;
    if (o_pc !== 1'b0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL run_abort: pc=%b busy=%b required 0 0", o_pc, o_busy);
    end
  endtask

  task automatic test_checksum();
    logic [8:0] w [8];
    sel = 2;
    w = '{9'h10A, 9'h0E4, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0};
`ifdef CPU_LOADER_CHECKSUM_EN
    load(w, 2, 1'b0, 1'b0);
    do_abort();
    load(w, 2, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      ser_valid = 1'b1; ser_bit = 1'($urandom); step();
    end
    ser_valid = 1'b0;
    n_tests++;
    if (o_err !== 1'b1 || o_pc !== 1'b0 || o_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL error_hold: err=%b pc=%b rdy=%b required 1 0 0", o_err, o_pc, o_rdy);
    end
    do_abort();
    n_tests++;
    if (o_err !== 1'b0 || o_pc !== 1'b0) begin
      n_fail++;
      $display("FAIL error_abort: err=%b pc=%b required 0 0", o_err, o_pc);
    end
`else
    load(w, 2, 1'b1, 1'b0);
    n_tests++;
    if (o_err !== 1'b0 || err7 !== 1'b0) begin
      n_fail++;
      $display("FAIL error_tied: err=%b/%b required 0", o_err, err7);
    end
    do_abort();
`endif
  endtask

  initial begin
    start2 = 1'b0; start7 = 1'b0; abort = 1'b0;
    ser_bit = 1'b0; ser_valid = 1'b0; reset = 1'b1;
    test_reset();
    test_basic_load();
    test_gapped_load();
    test_abort();
    test_run();
    test_checksum();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cpu_program_loader.md
Name: cpu_program_loader

Overview:
Upstream stage of the 3-bit CPU. It receives a program as a bit-serial stream, assembles 9-bit instruction words and writes them to CPU RAM addresses 0..PROG_LEN-1 through the RAM write port (RAM_Write_Data/Address/Enable). When the load completes it asserts PC_Enable, which starts execution. It replaces the manual RAM preload sequence.

Parameters:
DATA_W, 9, instruction word width (RAM word)
ADDR_W, 3, RAM address width
PROG_LEN, 7, number of words loaded; legal range 1..2**ADDR_W

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  single-cycle pulse; begins a load; honoured only in IDLE
abort  input  1  returns the loader to IDLE from any state; takes priority over start
ser_bit  input  1  serial program bit, MSB of each word first
ser_valid  input  1  ser_bit is valid this cycle
ser_ready  output  1  loader accepts a bit this cycle (a bit transfers when ser_valid && ser_ready)
RAM_Write_Data  output  DATA_W  word to the CPU RAM
RAM_Write_Address  output  ADDR_W  CPU RAM address
RAM_Write_Enable  output  1  one-cycle write strobe
PC_Enable  output  1  CPU run enable
busy  output  1  load in progress (SHIFT/WRITE/CHECK)
error  output  1  checksum failure (CHECKSUM_EN only; tied 0 otherwise)

Behaviour:
- All outputs are registered. While reset=0, all outputs are 0 immediately (asynchronously), state=IDLE, counters and shift register are 0.
- States: IDLE, SHIFT, WRITE, RUN; with CHECKSUM_EN also CHECK and ERROR.
- IDLE: all outputs 0. A cycle with start=1 and abort=0 -> SHIFT; word_cnt=0, bit_cnt=0.
- SHIFT: ser_ready=1. On each transfer: shreg <= {shreg[DATA_W-2:0], ser_bit}; bit_cnt++. Cycles with ser_valid=0 change nothing. The transfer of bit DATA_W (bit_cnt==DATA_W-1) moves to WRITE on the next edge and clears bit_cnt.
- WRITE: exactly one cycle. RAM_Write_Enable=1, RAM_Write_Data=assembled word, RAM_Write_Address=word_cnt. ser_ready=0, so no bit is accepted. Then, if word_cnt==PROG_LEN-1: go to RUN (or CHECK); else word_cnt++ and go to SHIFT.
- Latency: the write strobe is high in the cycle immediately after the edge that samples the last bit of a word.
- RAM_Write_Data/Address hold their last values while the strobe is low. They clear to 0 on abort or reset.
- RUN: PC_Enable=1 continuously, starting the cycle after the final WRITE. busy=0, ser_ready=0. start is ignored. Only abort or reset leaves RUN.
- abort=1 in any state: next edge -> IDLE; all outputs 0; counters cleared. A partial word is discarded. RAM contents already written are not undone.
- start=1 while not in IDLE is ignored. start and abort together resolve to abort.
- word_cnt never exceeds PROG_LEN-1; addresses never wrap within a load.
- busy=1 exactly in SHIFT, WRITE and CHECK.

Optional Feature:
CPU_LOADER_CHECKSUM_EN
- Defined: a running XOR of all written words is kept. After the last WRITE the state goes to CHECK (ser_ready=1) and shifts in one extra DATA_W-bit checksum word; no RAM write occurs for it.
  - Match -> RUN.
  - Mismatch -> ERROR: error=1, PC_Enable=0, ser_ready=0, held until abort or reset.
- Undefined: no CHECK or ERROR states; error is tied 0.

Test Plan:
1. Drive reset=0 asynchronously mid-load (between clock edges) -> all outputs 0 before the next edge; after release, state is IDLE and ser_ready=0.
2. PROG_LEN=2; start, then shift 9'h10A and 9'h0E4 on consecutive cycles -> strobes (addr 0, 9'h10A) then (addr 1, 9'h0E4), each one cycle long, one cycle after the 9th bit. PC_Enable=1 on the cycle after the second strobe; busy then falls.
3. Same program with ser_valid=0 inserted randomly between bits -> identical writes, no extra strobes, ser_valid ignored in the WRITE cycle.
4. PROG_LEN=7; abort after 4 bits of word 2 -> IDLE next cycle, only 2 strobes seen. A restart and full load writes addresses 0..6 starting from 0.
5. In RUN, pulse start -> no change. Pulse abort -> PC_Enable=0 on the next cycle.
6. CPU_LOADER_CHECKSUM_EN, PROG_LEN=2, words 9'h10A, 9'h0E4:
   - Checksum 9'h1EE -> PC_Enable=1, error=0.
   - Checksum 9'h1EF -> error=1, PC_Enable=0 until abort.
